// File: rtl/uart_arbiter_if.sv
// Bundle of per-master request/response signals and the shared uart register port.
// The arbiter takes the slave modport; the masters and the device model take the master modport.
interface uart_arbiter_if #(
   parameter int unsigned N_REQ   = 2,
   parameter int unsigned ADDR_SZ = 4,
   parameter int unsigned DATA_SZ = 8
);
   logic [N_REQ-1:0]         i_req;
   logic [N_REQ-1:0]         i_req_wr;
   logic [N_REQ*ADDR_SZ-1:0] i_req_addr;
   logic [N_REQ*DATA_SZ-1:0] i_req_data;
   logic [N_REQ-1:0]         o_gnt;
   logic [N_REQ-1:0]         o_rvalid;
   logic [DATA_SZ-1:0]       o_rdata;
   logic                     o_busy;
   logic                     o_en;
   logic                     o_wr;
   logic [ADDR_SZ-1:0]       o_addr;
   logic [DATA_SZ-1:0]       o_data;
   logic [DATA_SZ-1:0]       i_data;

   modport slave (
      input  i_req, i_req_wr, i_req_addr, i_req_data, i_data,
      output o_gnt, o_rvalid, o_rdata, o_busy, o_en, o_wr, o_addr, o_data
   );

   modport master (
      output i_req, i_req_wr, i_req_addr, i_req_data, i_data,
      input  o_gnt, o_rvalid, o_rdata, o_busy, o_en, o_wr, o_addr, o_data
   );
endinterface

// File: rtl/uart_arbiter.sv
// Round-robin arbiter sharing one uart register port among N_REQ masters.
// One access in flight; reads take an extra CAPTURE cycle for the device's one-cycle latency.
module uart_arbiter #(
   parameter int unsigned N_REQ   = 2,
   parameter int unsigned ADDR_SZ = 4,
   parameter int unsigned DATA_SZ = 8
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   uart_arbiter_if.slave  bus
);
   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   win_q, win_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic               acc_wr_q, acc_wr_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [N_REQ-1:0]   rvalid_q, rvalid_d;
   logic [DATA_SZ-1:0] rdata_q, rdata_d;
   logic               busy_q, busy_d;
   logic               en_q, en_d;
   logic               wr_q, wr_d;
   logic [ADDR_SZ-1:0] addr_q, addr_d;
   logic [DATA_SZ-1:0] data_q, data_d;

   logic               sel_found;
   logic [IDX_W-1:0]   sel_idx;
   logic               sel_wr;
   logic [ADDR_SZ-1:0] sel_addr;
   logic [DATA_SZ-1:0] sel_data;

   // Scan last+1, last+2, ... (mod N_REQ); the first requester found wins.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_data  = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         int unsigned cand;
         cand = (32'(last_q) + i) % N_REQ;
         if (!sel_found && ((bus.i_req >> cand) & N_REQ'(1)) != '0) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(cand);
            sel_wr    = |((bus.i_req_wr >> cand) & N_REQ'(1));
            sel_addr  = ADDR_SZ'(bus.i_req_addr >> (cand * ADDR_SZ));
            sel_data  = DATA_SZ'(bus.i_req_data >> (cand * DATA_SZ));
         end
      end
   end

   // Outputs are registered, so each is computed for the state being entered.
   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      last_d   = last_q;
      acc_wr_d = acc_wr_q;
      gnt_d    = '0;
      rvalid_d = '0;
      rdata_d  = rdata_q;
      en_d     = 1'b0;
      wr_d     = 1'b0;
      addr_d   = '0;
      data_d   = '0;
      unique case (state_q)
         IDLE: begin
            if (sel_found) begin
               win_d    = sel_idx;
               last_d   = sel_idx;
               acc_wr_d = sel_wr;
               gnt_d    = N_REQ'(1) << sel_idx;
               en_d     = 1'b1;
               wr_d     = sel_wr;
               addr_d   = sel_addr;
               data_d   = sel_data;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            state_d = acc_wr_q ? IDLE : CAPTURE;
         end
         CAPTURE: begin
            rdata_d  = bus.i_data;
            rvalid_d = N_REQ'(1) << win_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         win_q    <= '0;
         last_q   <= IDX_W'(N_REQ - 1);
         acc_wr_q <= 1'b0;
         gnt_q    <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
         busy_q   <= 1'b0;
         en_q     <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         last_q   <= last_d;
         acc_wr_q <= acc_wr_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         busy_q   <= busy_d;
         en_q     <= en_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end

   assign bus.o_gnt    = gnt_q;
   assign bus.o_rvalid = rvalid_q;
   assign bus.o_rdata  = rdata_q;
   assign bus.o_busy   = busy_q;
   assign bus.o_en     = en_q;
   assign bus.o_wr     = wr_q;
   assign bus.o_addr   = addr_q;
   assign bus.o_data   = data_q;
endmodule

// File: tb/tb_uart_arbiter.sv
// Directed bench for uart_arbiter: a 2-master instance driven by a per-cycle vector table
// and a 3-master instance for the rotating-read sequence, each with a small register-file device.
module tb_uart_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   uart_arbiter_if #(.N_REQ(2), .ADDR_SZ(4), .DATA_SZ(8)) b2 ();
   uart_arbiter_if #(.N_REQ(3), .ADDR_SZ(4), .DATA_SZ(8)) b3 ();

   uart_arbiter #(.N_REQ(2), .ADDR_SZ(4), .DATA_SZ(8)) u2 (.i_clk(clk), .i_rst_n(rst_n), .bus(b2));
   uart_arbiter #(.N_REQ(3), .ADDR_SZ(4), .DATA_SZ(8)) u3 (.i_clk(clk), .i_rst_n(rst_n), .bus(b3));

   // Device models: registered read (data valid the cycle after o_en), never reset.
   logic [7:0] mem2 [16];
   logic [7:0] mem3 [16];
   logic [7:0] dev2 = 8'h00;
   logic [7:0] dev3 = 8'h00;

   initial begin
      for (int i = 0; i < 16; i++) begin
         mem2[i] = 8'hA0 + 8'(i);
         mem3[i] = 8'hA0 + 8'(i);
      end
      mem2[3] = 8'h5A;
   end

   always @(posedge clk) begin
      if (b2.o_en) begin
         if (b2.o_wr) mem2[b2.o_addr] <= b2.o_data;
         else         dev2 <= mem2[b2.o_addr];
      end
      if (b3.o_en) begin
         if (b3.o_wr) mem3[b3.o_addr] <= b3.o_data;
         else         dev3 <= mem3[b3.o_addr];
      end
   end

   assign b2.i_data = dev2;
   assign b3.i_data = dev3;

   typedef struct {
      logic [1:0] req;
      logic [1:0] wr;
      logic [3:0] a0, a1;
      logic [7:0] d0, d1;
      logic [1:0] gnt;
      logic [1:0] rvalid;
      logic [7:0] rdata;
      logic       en;
      logic       owr;
      logic [3:0] oaddr;
      logic [7:0] odata;
      logic       busy;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(logic [1:0] req, logic [1:0] wr, logic [3:0] a0, logic [3:0] a1,
                               logic [7:0] d0, logic [7:0] d1, logic [1:0] gnt, logic [1:0] rvalid,
                               logic [7:0] rdata, logic en, logic owr, logic [3:0] oaddr,
                               logic [7:0] odata, logic busy);
      vec_t v;
      v.req = req; v.wr = wr; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
      v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata; v.en = en; v.owr = owr;
      v.oaddr = oaddr; v.odata = odata; v.busy = busy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive2(input logic [1:0] req, input logic [1:0] wr, input logic [3:0] a0,
                         input logic [3:0] a1, input logic [7:0] d0, input logic [7:0] d1);
      b2.i_req      = req;
      b2.i_req_wr   = wr;
      b2.i_req_addr = {a1, a0};
      b2.i_req_data = {d1, d0};
   endtask

   initial begin
      int cyc;
      logic [2:0] exp_oh;
      logic [7:0] exp_rd;

      // Test 2/3/4 plus a read whose inputs change after the latch.
      tv.push_back(mk(2'b01, 2'b01, 4'd1, 4'd0, 8'h41, 8'h00, 2'b01, 2'b00, 8'h00, 1, 1, 4'd1, 8'h41, 1));
      tv.push_back(mk(2'b00, 2'b00, 4'd1, 4'd0, 8'h41, 8'h00, 2'b00, 2'b00, 8'h00, 0, 0, 4'd0, 8'h00, 0));
      tv.push_back(mk(2'b00, 2'b00, 4'd1, 4'd0, 8'h41, 8'h00, 2'b00, 2'b00, 8'h00, 0, 0, 4'd0, 8'h00, 0));
      tv.push_back(mk(2'b10, 2'b00, 4'd0, 4'd3, 8'h00, 8'h00, 2'b10, 2'b00, 8'h00, 1, 0, 4'd3, 8'h00, 1));
      tv.push_back(mk(2'b00, 2'b00, 4'd0, 4'd3, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 0, 0, 4'd0, 8'h00, 1));
      tv.push_back(mk(2'b00, 2'b00, 4'd0, 4'd3, 8'h00, 8'h00, 2'b00, 2'b10, 8'h5A, 0, 0, 4'd0, 8'h00, 0));
      tv.push_back(mk(2'b00, 2'b00, 4'd0, 4'd3, 8'h00, 8'h00, 2'b00, 2'b00, 8'h5A, 0, 0, 4'd0, 8'h00, 0));
      tv.push_back(mk(2'b11, 2'b11, 4'd2, 4'd4, 8'h11, 8'h22, 2'b01, 2'b00, 8'h5A, 1, 1, 4'd2, 8'h11, 1));
      tv.push_back(mk(2'b11, 2'b11, 4'd2, 4'd4, 8'h11, 8'h22, 2'b00, 2'b00, 8'h5A, 0, 0, 4'd0, 8'h00, 0));
      tv.push_back(mk(2'b11, 2'b11, 4'd2, 4'd4, 8'h11, 8'h22, 2'b10, 2'b00, 8'h5A, 1, 1, 4'd4, 8'h22, 1));
      tv.push_back(mk(2'b11, 2'b11, 4'd2, 4'd4, 8'h11, 8'h22, 2'b00, 2'b00, 8'h5A, 0, 0, 4'd0, 8'h00, 0));
      tv.push_back(mk(2'b11, 2'b11, 4'd2, 4'd4, 8'h11, 8'h22, 2'b01, 2'b00, 8'h5A, 1, 1, 4'd2, 8'h11, 1));
      tv.push_back(mk(2'b11, 2'b11, 4'd2, 4'd4, 8'h11, 8'h22, 2'b00, 2'b00, 8'h5A, 0, 0, 4'd0, 8'h00, 0));
      tv.push_back(mk(2'b11, 2'b11, 4'd2, 4'd4, 8'h11, 8'h22, 2'b10, 2'b00, 8'h5A, 1, 1, 4'd4, 8'h22, 1));
      tv.push_back(mk(2'b00, 2'b00, 4'd2, 4'd4, 8'h11, 8'h22, 2'b00, 2'b00, 8'h5A, 0, 0, 4'd0, 8'h00, 0));
      tv.push_back(mk(2'b01, 2'b00, 4'd5, 4'd0, 8'h33, 8'h00, 2'b01, 2'b00, 8'h5A, 1, 0, 4'd5, 8'h33, 1));
      tv.push_back(mk(2'b01, 2'b00, 4'd7, 4'd0, 8'h44, 8'h00, 2'b00, 2'b00, 8'h5A, 0, 0, 4'd0, 8'h00, 1));
      tv.push_back(mk(2'b00, 2'b00, 4'd7, 4'd0, 8'h44, 8'h00, 2'b00, 2'b01, 8'hA5, 0, 0, 4'd0, 8'h00, 0));
      tv.push_back(mk(2'b00, 2'b00, 4'd7, 4'd0, 8'h44, 8'h00, 2'b00, 2'b00, 8'hA5, 0, 0, 4'd0, 8'h00, 0));

      drive2(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
      b3.i_req = '0; b3.i_req_wr = '0; b3.i_req_addr = '0; b3.i_req_data = '0;

      // Test 1: reset values, then first tie goes to master 0.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_en", 32'(b2.o_en), 32'd0);
      chk("rst_gnt", 32'(b2.o_gnt), 32'd0);
      chk("rst_rvalid", 32'(b2.o_rvalid), 32'd0);
      chk("rst_busy", 32'(b2.o_busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      drive2(2'b11, 2'b11, 4'd0, 4'd9, 8'h10, 8'h99);
      @(posedge clk); #1;
      chk("tie_gnt", 32'(b2.o_gnt), 32'h1);
      chk("tie_addr", 32'(b2.o_addr), 32'h0);
      chk("tie_data", 32'(b2.o_data), 32'h10);
      @(negedge clk);
      drive2(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
      @(posedge clk); #1;
      chk("tie_idle_gnt", 32'(b2.o_gnt), 32'h0);

      foreach (tv[i]) begin
         @(negedge clk);
         drive2(tv[i].req, tv[i].wr, tv[i].a0, tv[i].a1, tv[i].d0, tv[i].d1);
         @(posedge clk); #1;
         chk($sformatf("v%0d_gnt", i), 32'(b2.o_gnt), 32'(tv[i].gnt));
         chk($sformatf("v%0d_rvalid", i), 32'(b2.o_rvalid), 32'(tv[i].rvalid));
         chk($sformatf("v%0d_rdata", i), 32'(b2.o_rdata), 32'(tv[i].rdata));
         chk($sformatf("v%0d_en", i), 32'(b2.o_en), 32'(tv[i].en));
         chk($sformatf("v%0d_wr", i), 32'(b2.o_wr), 32'(tv[i].owr));
         chk($sformatf("v%0d_addr", i), 32'(b2.o_addr), 32'(tv[i].oaddr));
         chk($sformatf("v%0d_data", i), 32'(b2.o_data), 32'(tv[i].odata));
         chk($sformatf("v%0d_busy", i), 32'(b2.o_busy), 32'(tv[i].busy));
      end

      // Test 6: reset asserted during CAPTURE drops the pending o_rvalid.
      @(negedge clk);
      drive2(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00);
      @(posedge clk); #1;
      chk("rm_gnt", 32'(b2.o_gnt), 32'h1);
      @(negedge clk);
      drive2(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
      @(posedge clk); #1;
      chk("rm_busy_capture", 32'(b2.o_busy), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("rm_busy_in_rst", 32'(b2.o_busy), 32'h0);
      chk("rm_rvalid_in_rst", 32'(b2.o_rvalid), 32'h0);
      @(posedge clk); #1;
      chk("rm_rvalid_held", 32'(b2.o_rvalid), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rm_busy_after", 32'(b2.o_busy), 32'h0);
      chk("rm_rvalid_after", 32'(b2.o_rvalid), 32'h0);
      chk("rm_rdata_after", 32'(b2.o_rdata), 32'h0);
      @(negedge clk);
      drive2(2'b11, 2'b11, 4'd1, 4'd2, 8'h01, 8'h02);
      @(posedge clk); #1;
      chk("rm_tie_gnt", 32'(b2.o_gnt), 32'h1);
      @(negedge clk);
      drive2(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);

      // Test 5: N_REQ=3, masters 0 and 2 read continuously; order 0,2,0,2.
      b3.i_req      = 3'b101;
      b3.i_req_wr   = 3'b000;
      b3.i_req_addr = {4'd8, 4'd0, 4'd6};
      b3.i_req_data = '0;
      for (int n = 0; n < 4; n++) begin
         exp_oh = (n % 2 == 0) ? 3'b001 : 3'b100;
         exp_rd = (n % 2 == 0) ? 8'hA6 : 8'hA8;
         cyc = 0;
         while (b3.o_gnt == '0 && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
         end
         chk($sformatf("n3_gnt%0d", n), 32'(b3.o_gnt), 32'(exp_oh));
         cyc = 0;
         while (b3.o_rvalid == '0 && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
         end
         chk($sformatf("n3_rvalid%0d", n), 32'(b3.o_rvalid), 32'(exp_oh));
         chk($sformatf("n3_rdata%0d", n), 32'(b3.o_rdata), 32'(exp_rd));
      end
      @(negedge clk);
      b3.i_req = '0;
      repeat (4) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
